// File: rtl/sinfonia_pkg.sv
// Shared definitions for the Sinfonia do Espectro engine: state encoding,
// LFSR feedback taps and one-hot decoding.
package sinfonia_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        GERA       = 4'd1,
        TOCA_NOTA  = 4'd2,
        TOCA_PAUSA = 4'd3,
        ESPERA     = 4'd4,
        CONFERE    = 4'd5,
        PROX       = 4'd6,
        FIM_ACERTO = 4'd7,
        FIM_ERRO   = 4'd8
    } estado_t;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] onehot_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sinfonia_motor_param_if.sv
// Player-facing bundle of the game engine: start/mode/buttons in, note,
// score and status out.
interface sinfonia_motor_param_if #(
    parameter int N_BOTOES = 7,
    parameter int PROF     = 16
);
    localparam int W  = $clog2(N_BOTOES);
    localparam int RW = $clog2(PROF + 1);

    logic                jogar;
    logic                treinamento;
    logic [N_BOTOES-1:0] botoes;
    logic                nota_valida;
    logic [W-1:0]        nota_idx;
    logic                pronto;
    logic                acertou;
    logic                errou;
    logic [7:0]          pontos;
    logic [RW-1:0]       rodada;
    logic [3:0]          db_estado;

    modport master (
        output jogar, treinamento, botoes,
        input  nota_valida, nota_idx, pronto, acertou, errou, pontos, rodada, db_estado
    );

    modport slave (
        input  jogar, treinamento, botoes,
        output nota_valida, nota_idx, pronto, acertou, errou, pontos, rodada, db_estado
    );

endinterface

// File: rtl/gerador_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; the seed is loaded on reset.
module gerador_lfsr
    import sinfonia_pkg::*;
#(
    parameter logic [7:0] SEMENTE = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= SEMENTE;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sinfonia_motor_param.sv
// Memory game engine: grows a random note sequence each round, plays it back
// and scores the player's presses against it.
module sinfonia_motor_param
    import sinfonia_pkg::*;
#(
    parameter int         N_BOTOES   = 7,
    parameter int         PROF       = 16,
    parameter int         T_NOTA     = 1000,
    parameter int         T_PAUSA    = 250,
    parameter int         TIMEOUT    = 5000,
    parameter logic [7:0] PONTOS_INI = 8'd100,
    parameter logic [7:0] PENALIDADE = 8'd10,
    parameter logic [7:0] SEMENTE    = 8'hA5
) (
    input logic                   clock,
    input logic                   reset,
    sinfonia_motor_param_if.slave bus
);

    localparam int W     = $clog2(N_BOTOES);
    localparam int RW    = $clog2(PROF + 1);
    localparam int AW    = $clog2(PROF);
    localparam int T_MAX = (T_NOTA > T_PAUSA) ? ((T_NOTA > TIMEOUT) ? T_NOTA : TIMEOUT)
                                              : ((T_PAUSA > TIMEOUT) ? T_PAUSA : TIMEOUT);
    localparam int TW    = $clog2(T_MAX + 1);

    estado_t             state_q, state_d;
    logic [RW-1:0]       rodada_q, rodada_d;
    logic [RW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [7:0]          pontos_q, pontos_d;
    logic                treino_q, treino_d;
    logic                pronto_q, pronto_d;
    logic                acertou_q, acertou_d;
    logic                errou_q, errou_d;
    logic [N_BOTOES-1:0] lat_q, lat_d;
    logic                any_prev_q;
    logic [W-1:0]        mem [PROF];

    logic [7:0]   lfsr;
    logic         we, falha, press, correto, ultimo;
    logic [W-1:0] nota_lfsr, nota_mem, nota_lat;
    logic [7:0]   pontos_pen;

    gerador_lfsr #(.SEMENTE(SEMENTE)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr_o(lfsr)
    );

    assign press      = (|bus.botoes) && !any_prev_q;
    assign nota_lfsr  = W'(int'(lfsr) % N_BOTOES);
    assign nota_mem   = mem[idx_q[AW-1:0]];
    assign nota_lat   = W'(onehot_idx(16'(lat_q)));
    assign correto    = $onehot(lat_q) && (nota_lat == nota_mem);
    assign ultimo     = (idx_q + 1'b1) == rodada_q;
    assign pontos_pen = (pontos_q > PENALIDADE) ? pontos_q - PENALIDADE : '0;

    always_comb begin
        state_d   = state_q;
        rodada_d  = rodada_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        pontos_d  = pontos_q;
        treino_d  = treino_q;
        pronto_d  = pronto_q;
        acertou_d = acertou_q;
        errou_d   = errou_q;
        lat_d     = lat_q;
        we        = 1'b0;
        falha     = 1'b0;
        case (state_q)
            INICIAL, FIM_ACERTO, FIM_ERRO: begin
                if (bus.jogar) begin
                    rodada_d  = '0;
                    idx_d     = '0;
                    treino_d  = bus.treinamento;
                    pontos_d  = PONTOS_INI;
                    pronto_d  = 1'b0;
                    acertou_d = 1'b0;
                    errou_d   = 1'b0;
                    state_d   = GERA;
                end
            end
            GERA: begin
                we       = 1'b1;
                rodada_d = rodada_q + 1'b1;
                idx_d    = '0;
                timer_d  = '0;
                state_d  = TOCA_NOTA;
            end
            TOCA_NOTA: begin
                if (timer_q == TW'(T_NOTA - 1)) begin
                    timer_d = '0;
                    state_d = TOCA_PAUSA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TOCA_PAUSA: begin
                if (timer_q == TW'(T_PAUSA - 1)) begin
                    timer_d = '0;
                    idx_d   = ultimo ? '0 : idx_q + 1'b1;
                    state_d = ultimo ? ESPERA : TOCA_NOTA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ESPERA: begin
                if (press) begin
                    lat_d   = bus.botoes;
                    state_d = CONFERE;
                end else if (!treino_q) begin
                    if (timer_q == TW'(TIMEOUT - 1)) falha = 1'b1;
                    else                              timer_d = timer_q + 1'b1;
                end
            end
            CONFERE: begin
                // correct non-final presses park here until all buttons are released
                if (!correto) begin
                    falha = 1'b1;
                end else if (ultimo) begin
                    state_d = PROX;
                end else if (bus.botoes == '0) begin
                    idx_d   = idx_q + 1'b1;
                    timer_d = '0;
                    state_d = ESPERA;
                end
            end
            PROX: begin
                if (rodada_q == RW'(PROF)) begin
                    pronto_d  = 1'b1;
                    acertou_d = 1'b1;
                    state_d   = FIM_ACERTO;
                end else begin
                    state_d = GERA;
                end
            end
            default: state_d = INICIAL;
        endcase

        // wrong press or timeout: replay the round unless the score runs out
        if (falha) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = TOCA_NOTA;
            if (!treino_q) begin
                pontos_d = pontos_pen;
                if (pontos_pen == '0) begin
                    pronto_d = 1'b1;
                    errou_d  = 1'b1;
                    state_d  = FIM_ERRO;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INICIAL;
            rodada_q   <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            pontos_q   <= PONTOS_INI;
            treino_q   <= 1'b0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            lat_q      <= '0;
            any_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rodada_q   <= rodada_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            pontos_q   <= pontos_d;
            treino_q   <= treino_d;
            pronto_q   <= pronto_d;
            acertou_q  <= acertou_d;
            errou_q    <= errou_d;
            lat_q      <= lat_d;
            any_prev_q <= |bus.botoes;
        end
    end

    always_ff @(posedge clock) begin
        if (we) mem[rodada_q[AW-1:0]] <= nota_lfsr;
    end

    always_comb begin
        bus.nota_idx = '0;
        if (state_q == TOCA_NOTA)    bus.nota_idx = nota_mem;
        else if (state_q == CONFERE) bus.nota_idx = nota_lat;
    end

    assign bus.nota_valida = (state_q == TOCA_NOTA);
    assign bus.pronto      = pronto_q;
    assign bus.acertou     = acertou_q;
    assign bus.errou       = errou_q;
    assign bus.pontos      = pontos_q;
    assign bus.rodada      = rodada_q;
    assign bus.db_estado   = state_q;

endmodule
